// File: rtl/out_capture_pkg.sv
// Shared types and helpers for the output signature capture stage:
// FSM state encoding, default polynomial/seed and the SISR step function.
package out_capture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } cap_state_t;

    localparam int          SIG_MAX  = 64;
    localparam logic [15:0] DEF_POLY = 16'h1021;
    localparam logic [15:0] DEF_SEED = 16'h0000;

    // One SISR step on a register of 'width' bits (width <= SIG_MAX); upper bits are cleared.
    function automatic logic [SIG_MAX-1:0] sisr_next(
        input logic [SIG_MAX-1:0] sig,
        input logic               din,
        input logic [SIG_MAX-1:0] poly,
        input int                 width
    );
        logic               fb;
        logic [SIG_MAX-1:0] mask;
        fb   = sig[6'(width - 1)] ^ din;
        mask = (width >= SIG_MAX) ? {SIG_MAX{1'b1}}
                                  : ((SIG_MAX'(1) << width) - SIG_MAX'(1));
        return ((sig << 1) ^ (fb ? poly : {SIG_MAX{1'b0}})) & mask;
    endfunction

endpackage

// File: rtl/out_signature_capture_sisr_shift.sv
// Serial-input signature register: loads SEED on 'load', absorbs one din bit per 'shift'.
module sisr_shift
    import out_capture_pkg::*;
#(
    parameter int               SIG_W = 16,
    parameter logic [SIG_W-1:0] POLY  = DEF_POLY,
    parameter logic [SIG_W-1:0] SEED  = DEF_SEED
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             shift,
    input  logic             din,
    output logic [SIG_W-1:0] sig
);

    logic [SIG_W-1:0] sig_r;
    logic [SIG_W-1:0] next_s;

    // Next signature value for the current din bit.
    always_comb begin
        next_s = SIG_W'(sisr_next(SIG_MAX'(sig_r), din, SIG_MAX'(POLY), SIG_W));
    end

    // Signature register; load has priority so a new window always starts from SEED.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_r <= SEED;
        end else if (load) begin
            sig_r <= SEED;
        end else if (shift) begin
            sig_r <= next_s;
        end else begin
            sig_r <= sig_r;
        end
    end

    assign sig = sig_r;

endmodule

// File: rtl/out_signature_capture.sv
// Capture stage compacting 'len' serial path samples into a signature and comparing to golden.
// Optional ones counter enabled by defining OUT_CAPTURE_ONES_CNT_EN.
module out_signature_capture
    import out_capture_pkg::*;
#(
    parameter int               SIG_W = 16,
    parameter logic [SIG_W-1:0] POLY  = DEF_POLY,
    parameter logic [SIG_W-1:0] SEED  = DEF_SEED,
    parameter int               CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             din,
    input  logic [SIG_W-1:0] golden,
    output logic             busy,
    output logic             done,
    output logic [SIG_W-1:0] signature,
`ifdef OUT_CAPTURE_ONES_CNT_EN
    output logic [CNT_W-1:0] ones_cnt,
`endif
    output logic             pass
);

    cap_state_t       state_r;
    logic [CNT_W-1:0] remain_r;
    logic             busy_r;
    logic             done_r;
    logic             accept_s;
    logic             shift_s;
    logic [SIG_W-1:0] sig_s;

    // start is only honoured outside RUN; RUN edges absorb din.
    always_comb begin
        accept_s = start & (state_r != ST_RUN);
        shift_s  = (state_r == ST_RUN);
    end

    // Window FSM with remaining-sample counter and registered status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            remain_r <= {CNT_W{1'b0}};
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start && (len != {CNT_W{1'b0}})) begin
                        state_r  <= ST_RUN;
                        remain_r <= len;
                        busy_r   <= 1'b1;
                        done_r   <= 1'b0;
                    end else if (start) begin
                        state_r  <= ST_DONE;
                        remain_r <= {CNT_W{1'b0}};
                        busy_r   <= 1'b0;
                        done_r   <= 1'b1;
                    end else begin
                        state_r  <= state_r;
                        remain_r <= remain_r;
                        busy_r   <= busy_r;
                        done_r   <= done_r;
                    end
                end
                ST_RUN: begin
                    remain_r <= remain_r - CNT_W'(1);
                    if (remain_r == CNT_W'(1)) begin
                        state_r <= ST_DONE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end else begin
                        state_r <= ST_RUN;
                        busy_r  <= 1'b1;
                        done_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    remain_r <= {CNT_W{1'b0}};
                    busy_r   <= 1'b0;
                    done_r   <= 1'b0;
                end
            endcase
        end
    end

    sisr_shift #(
        .SIG_W (SIG_W),
        .POLY  (POLY),
        .SEED  (SEED)
    ) u_sisr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (accept_s),
        .shift (shift_s),
        .din   (din),
        .sig   (sig_s)
    );

`ifdef OUT_CAPTURE_ONES_CNT_EN
    logic [CNT_W-1:0] ones_cnt_r;

    // Saturating count of ones absorbed in the current window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ones_cnt_r <= {CNT_W{1'b0}};
        end else if (accept_s) begin
            ones_cnt_r <= {CNT_W{1'b0}};
        end else if (shift_s && din && (ones_cnt_r != {CNT_W{1'b1}})) begin
            ones_cnt_r <= ones_cnt_r + CNT_W'(1);
        end else begin
            ones_cnt_r <= ones_cnt_r;
        end
    end

    assign ones_cnt = ones_cnt_r;
`endif

    assign busy      = busy_r;
    assign done      = done_r;
    assign signature = sig_s;
    // golden is allowed to move while in DONE, so the compare stays combinational.
    assign pass      = done_r & (sig_s == golden);

endmodule

// File: tb/tb_out_signature_capture.sv
// Self-checking bench for out_signature_capture: directed table, corner sequences and random windows.
module tb_out_signature_capture;

    localparam int          SIG_W = 16;
    localparam int          CNT_W = 16;
    localparam logic [15:0] POLY  = 16'h1021;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [CNT_W-1:0] len;
    logic             din;
    logic [SIG_W-1:0] golden;
    logic             busy;
    logic             done;
    logic [SIG_W-1:0] signature;
    logic             pass;
`ifdef OUT_CAPTURE_ONES_CNT_EN
    logic [CNT_W-1:0] ones_cnt;
`endif

    int checks;
    int failures;

    out_signature_capture dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .len       (len),
        .din       (din),
        .golden    (golden),
        .busy      (busy),
        .done      (done),
        .signature (signature),
`ifdef OUT_CAPTURE_ONES_CNT_EN
        .ones_cnt  (ones_cnt),
`endif
        .pass      (pass)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          n;
        logic [63:0] bits;     // bit i is the din value of sample i
        logic [15:0] gold;
        logic [15:0] exp_sig;
        logic        exp_pass;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: CRC-style division of the sample stream, seed 0, input folded at the MSB.
    function automatic logic [15:0] model_sig(input int n, input logic [63:0] bits);
        int s;
        s = 0;
        for (int i = 0; i < n; i++) begin
            if (((s / 32768) % 2) != int'(bits[i])) s = ((s * 2) % 65536) ^ int'(POLY);
            else s = (s * 2) % 65536;
        end
        return 16'(s);
    endfunction

    function automatic int model_ones(input int n, input logic [63:0] bits);
        int c;
        c = 0;
        for (int i = 0; i < n; i++) c += int'(bits[i]);
        return c;
    endfunction

    task automatic run_window(input string tag, input int n, input logic [63:0] bits,
                              input logic [15:0] gold, input logic [15:0] exp_sig,
                              input logic exp_pass);
        start  = 1'b1;
        len    = CNT_W'(n);
        golden = gold;
        step();
        start = 1'b0;
        len   = CNT_W'($urandom_range(0, 65535));
        if (n == 0) begin
            chk({tag, ".done_len0"}, 64'(done), 64'd1);
            chk({tag, ".busy_len0"}, 64'(busy), 64'd0);
        end else begin
            chk({tag, ".busy_start"}, 64'(busy), 64'd1);
            chk({tag, ".done_drop"}, 64'(done), 64'd0);
            for (int i = 0; i < n; i++) begin
                din = bits[i];
                step();
                if (i < n - 1) chk({tag, ".busy_run"}, 64'(busy), 64'd1);
            end
            din = 1'b0;
            chk({tag, ".done"}, 64'(done), 64'd1);
            chk({tag, ".busy_end"}, 64'(busy), 64'd0);
        end
        chk({tag, ".sig"}, 64'(signature), 64'(exp_sig));
        chk({tag, ".pass"}, 64'(pass), 64'(exp_pass));
`ifdef OUT_CAPTURE_ONES_CNT_EN
        chk({tag, ".ones"}, 64'(ones_cnt), 64'(model_ones(n, bits)));
`endif
    endtask

    vec_t        vecs[$];
    logic [63:0] rbits;
    logic [15:0] rsig;
    logic [15:0] rgold;
    int          rn;

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        len      = '0;
        din      = 1'b0;
        golden   = 16'h0000;

        vecs.push_back('{1, 64'h1, 16'h1021, 16'h1021, 1'b1});
        vecs.push_back('{2, 64'h1, 16'h2043, 16'h2042, 1'b0});
        vecs.push_back('{3, 64'h0, 16'h0000, 16'h0000, 1'b1});
        vecs.push_back('{0, 64'h0, 16'h0000, 16'h0000, 1'b1});
        vecs.push_back('{3, 64'h7, 16'h70E7, 16'h70E7, 1'b1});
        vecs.push_back('{3, 64'h7, 16'h70E6, 16'h70E7, 1'b0});

        // Reset state
        step();
        step();
        chk("reset.busy", 64'(busy), 64'd0);
        chk("reset.done", 64'(done), 64'd0);
        chk("reset.sig", 64'(signature), 64'h0);
        chk("reset.pass", 64'(pass), 64'd0);
        rst_n = 1'b1;
        step();
        chk("idle.done", 64'(done), 64'd0);

        // T1: asynchronous reset in the middle of a window
        start = 1'b1;
        len   = 16'd8;
        step();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            din = 1'b1;
            step();
        end
        chk("t1.busy_before", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("t1.busy", 64'(busy), 64'd0);
        chk("t1.done", 64'(done), 64'd0);
        chk("t1.sig", 64'(signature), 64'h0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) step();
        chk("t1.no_done", 64'(done), 64'd0);
        chk("t1.idle_busy", 64'(busy), 64'd0);

        // Directed table (T2, T3, T5 sequencing from DONE)
        foreach (vecs[k]) begin
            run_window($sformatf("tab%0d", k), vecs[k].n, vecs[k].bits, vecs[k].gold,
                       vecs[k].exp_sig, vecs[k].exp_pass);
        end

        // DONE holds; golden changes are reflected on pass immediately
        step();
        step();
        chk("hold.done", 64'(done), 64'd1);
        chk("hold.sig", 64'(signature), 64'h70E7);
        golden = 16'h70E7;
        #1;
        chk("gold.pass_hi", 64'(pass), 64'd1);
        golden = 16'hFFFF;
        #1;
        chk("gold.pass_lo", 64'(pass), 64'd0);

        // T4: len=0 then a window where start and len change mid-run
        run_window("t4a", 0, 64'h0, 16'h0000, 16'h0000, 1'b1);
        start = 1'b1;
        len   = 16'd4;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            din   = 1'b1;
            start = (i == 1);
            len   = (i == 1) ? 16'd9 : 16'd2;
            step();
        end
        start = 1'b0;
        din   = 1'b0;
        chk("t4.done", 64'(done), 64'd1);
        chk("t4.sig", 64'(signature), 64'(model_sig(4, 64'hF)));
        step();
        chk("t4.done_hold", 64'(done), 64'd1);

        // T6-style ones count and clear on next start
        run_window("t6", 5, 64'h0D, 16'h0000, model_sig(5, 64'h0D), model_sig(5, 64'h0D) == 16'h0);
`ifdef OUT_CAPTURE_ONES_CNT_EN
        start = 1'b1;
        len   = 16'd2;
        step();
        start = 1'b0;
        chk("t6.ones_clear", 64'(ones_cnt), 64'd0);
        step();
        step();
`endif

        // Random windows against the reference model
        for (int r = 0; r < 30; r++) begin
            rn    = $urandom_range(0, 40);
            rbits = {$urandom(), $urandom()};
            rsig  = model_sig(rn, rbits);
            rgold = ($urandom_range(0, 1) == 1) ? rsig : (rsig ^ 16'(1 << $urandom_range(0, 15)));
            run_window($sformatf("rnd%0d", r), rn, rbits, rgold, rsig, rgold == rsig);
            for (int w = $urandom_range(0, 2); w > 0; w--) step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
